seq_shift_add_mult: RTL and testbench

//   Iterative unsigned shift-and-add multiplier for the multiplier group.

---
 rtl/seq_shift_add_mult.sv | 173 +++++++++++++++++
 tb/tb_seq_shift_add_mult.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_shift_add_mult.sv
// ---------------------------------------------------------------------------
// seq_shift_add_mult
// Iterative unsigned shift-and-add multiplier. One multiplier bit is
// resolved per clock; a WIDTH-bit by WIDTH-bit product takes WIDTH RUN
// cycles followed by a single DONE cycle that pulses 'done'. The product
// register only changes on entry to DONE, so 'p' is stable at all other
// times and may be sampled any time after the done pulse.
// ---------------------------------------------------------------------------
module seq_shift_add_mult #(
   parameter int WIDTH = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   p
);

   // Product width and iteration counter sizing. The counter is sized to
   // hold WIDTH itself so the post-increment on the last iteration never
   // wraps, even for the smallest legal WIDTH.
   localparam int PW    = 2 * WIDTH;
   localparam int CNT_W = $clog2(WIDTH + 1);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

   // Controller states; the encoding leaves 2'b11 unused and that value
   // recovers to IDLE.
   localparam logic [1:0] ST_IDLE = 2'b00;
   localparam logic [1:0] ST_RUN  = 2'b01;
   localparam logic [1:0] ST_DONE = 2'b10;

   // Registered state
   logic [1:0]        state_r;
   logic [PW-1:0]     mcand_r;
   logic [WIDTH-1:0]  mplier_r;
   logic [PW-1:0]     acc_r;
   logic [CNT_W-1:0]  cnt_r;
   logic              busy_r;
   logic              done_r;
   logic [PW-1:0]     p_r;

   // Next-state values
   logic [1:0]        state_s;
   logic [PW-1:0]     mcand_s;
   logic [WIDTH-1:0]  mplier_s;
   logic [PW-1:0]     acc_s;
   logic [CNT_W-1:0]  cnt_s;
   logic              busy_s;
   logic              done_s;
   logic [PW-1:0]     p_s;

   // Partial-product term and running sum for the current iteration.
   logic [PW-1:0]     addend_s;
   logic [PW-1:0]     sum_s;
   logic              last_iter_s;

   // Select the partial product for this iteration and form the sum; the
   // accumulator is twice the operand width so the add can never overflow.
   always_comb begin
      addend_s    = {PW{1'b0}};
      sum_s       = {PW{1'b0}};
      last_iter_s = 1'b0;
      if (mplier_r[0]) begin
         addend_s = mcand_r;
      end else begin
         addend_s = {PW{1'b0}};
      end
      sum_s       = acc_r + addend_s;
      last_iter_s = (cnt_r == CNT_LAST);
   end

   // Controller and datapath next-state logic. busy_s/done_s describe the
   // output values that will be visible after the coming edge, which keeps
   // the outputs registered without an extra cycle of latency.
   always_comb begin
      state_s  = state_r;
      mcand_s  = mcand_r;
      mplier_s = mplier_r;
      acc_s    = acc_r;
      cnt_s    = cnt_r;
      p_s      = p_r;
      busy_s   = 1'b0;
      done_s   = 1'b0;

      case (state_r)
         ST_IDLE: begin
            if (start) begin
               // Operands are captured here; later changes on a/b are
               // invisible to the in-flight operation.
               mcand_s  = {{WIDTH{1'b0}}, a};
               mplier_s = b;
               acc_s    = {PW{1'b0}};
               cnt_s    = CNT_ZERO;
               state_s  = ST_RUN;
               busy_s   = 1'b1;
            end else begin
               state_s  = ST_IDLE;
               busy_s   = 1'b0;
            end
         end

         ST_RUN: begin
            // Every iteration runs, even with a zero multiplier, so the
            // latency is independent of operand values.
            acc_s    = sum_s;
            mcand_s  = mcand_r << 1;
            mplier_s = mplier_r >> 1;
            cnt_s    = cnt_r + CNT_ONE;
            busy_s   = 1'b1;
            if (last_iter_s) begin
               p_s     = sum_s;
               state_s = ST_DONE;
               done_s  = 1'b1;
            end else begin
               state_s = ST_RUN;
               done_s  = 1'b0;
            end
         end

         ST_DONE: begin
            // Single done cycle; start is not looked at until IDLE.
            state_s = ST_IDLE;
            busy_s  = 1'b0;
            done_s  = 1'b0;
         end

         default: begin
            state_s  = ST_IDLE;
            mcand_s  = {PW{1'b0}};
            mplier_s = {WIDTH{1'b0}};
            acc_s    = {PW{1'b0}};
            cnt_s    = CNT_ZERO;
            busy_s   = 1'b0;
            done_s   = 1'b0;
         end
      endcase
   end

   // State, datapath and output registers with asynchronous clear; a reset
   // mid-operation aborts without a done pulse and clears the product.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r  <= ST_IDLE;
         mcand_r  <= {PW{1'b0}};
         mplier_r <= {WIDTH{1'b0}};
         acc_r    <= {PW{1'b0}};
         cnt_r    <= CNT_ZERO;
         busy_r   <= 1'b0;
         done_r   <= 1'b0;
         p_r      <= {PW{1'b0}};
      end else begin
         state_r  <= state_s;
         mcand_r  <= mcand_s;
         mplier_r <= mplier_s;
         acc_r    <= acc_s;
         cnt_r    <= cnt_s;
         busy_r   <= busy_s;
         done_r   <= done_s;
         p_r      <= p_s;
      end
   end

   assign busy = busy_r;
   assign done = done_r;
   assign p    = p_r;

endmodule

// File: tb/tb_seq_shift_add_mult.sv
// ---------------------------------------------------------------------------
// tb_seq_shift_add_mult
// Bench for the shift-and-add multiplier at WIDTH=4 and WIDTH=8. Expected
// products are pushed to a per-instance queue when an operation is issued
// and popped by a monitor whenever the DUT pulses done.
// ---------------------------------------------------------------------------
module tb_seq_shift_add_mult;

   logic        clk;
   logic        rst_n;

   logic        start4;
   logic [3:0]  a4;
   logic [3:0]  b4;
   logic        busy4;
   logic        done4;
   logic [7:0]  p4;

   logic        start8;
   logic [7:0]  a8;
   logic [7:0]  b8;
   logic        busy8;
   logic        done8;
   logic [15:0] p8;

   int          n_checks;
   int          n_errors;
   int          dones4;
   int          dones8;
   logic [7:0]  q4[$];
   logic [15:0] q8[$];
   logic [7:0]  e4;
   logic [15:0] e8;

   typedef struct {
      logic [3:0] a;
      logic [3:0] b;
      logic [7:0] exp;
      string      name;
   } vec_t;

   vec_t tbl[7];

   seq_shift_add_mult #(.WIDTH(4)) dut4 (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start4),
      .a     (a4),
      .b     (b4),
      .busy  (busy4),
      .done  (done4),
      .p     (p4)
   );

   seq_shift_add_mult #(.WIDTH(8)) dut8 (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start8),
      .a     (a8),
      .b     (b8),
      .busy  (busy8),
      .done  (done8),
      .p     (p8)
   );

   // Free-running clock, 10 time units per period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // Scoreboard monitor: each done pulse must match the oldest expectation.
   always @(negedge clk) begin
      if (done4) begin
         dones4++;
         if (q4.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL p4_unexpected_done: got p=%0d expected no done", p4);
         end else begin
            e4 = q4.pop_front();
            check("p4_product", 32'(p4), 32'(e4));
         end
      end
      if (done8) begin
         dones8++;
         if (q8.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL p8_unexpected_done: got p=%0d expected no done", p8);
         end else begin
            e8 = q8.pop_front();
            check("p8_product", 32'(p8), 32'(e8));
         end
      end
   end

   // One WIDTH=4 operation with latency, busy-length and hold checks.
   // With scramble set, a/b are randomised every cycle while busy.
   task automatic op4(input logic [3:0] aa, input logic [3:0] bb,
                      input logic [7:0] exp, input string nm, input bit scramble);
      int busy_cnt;
      int done_cnt;
      int done_idx;
      @(negedge clk);
      a4 = aa; b4 = bb; start4 = 1'b1;
      q4.push_back(exp);
      @(posedge clk);
      busy_cnt = 0; done_cnt = 0; done_idx = -1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (i == 0) start4 = 1'b0;
         if (busy4) busy_cnt++;
         if (done4) begin
            done_cnt++;
            if (done_idx < 0) done_idx = i;
         end
         if (scramble && busy4) begin
            a4 = 4'($urandom_range(0, 15));
            b4 = 4'($urandom_range(0, 15));
         end
      end
      check({nm, "_done_latency"}, 32'(done_idx), 32'd4);
      check({nm, "_done_pulses"}, 32'(done_cnt), 32'd1);
      check({nm, "_busy_cycles"}, 32'(busy_cnt), 32'd5);
      check({nm, "_p_hold"}, 32'(p4), 32'(exp));
   endtask

   // One WIDTH=8 operation; latency is checked on every call.
   task automatic op8(input logic [7:0] aa, input logic [7:0] bb, input string nm);
      int busy_cnt;
      int done_idx;
      logic [15:0] exp;
      exp = 16'(aa) * 16'(bb);
      @(negedge clk);
      a8 = aa; b8 = bb; start8 = 1'b1;
      q8.push_back(exp);
      @(posedge clk);
      busy_cnt = 0; done_idx = -1;
      for (int i = 0; i < 11; i++) begin
         @(negedge clk);
         if (i == 0) start8 = 1'b0;
         if (busy8) busy_cnt++;
         if (done8 && done_idx < 0) done_idx = i;
      end
      check({nm, "_done_latency"}, 32'(done_idx), 32'd8);
      check({nm, "_busy_cycles"}, 32'(busy_cnt), 32'd9);
   endtask

   initial begin
      logic [31:0] done_mask;
      int          d0;

      n_checks = 0; n_errors = 0; dones4 = 0; dones8 = 0;

      tbl[0] = '{a: 4'd3,  b: 4'd5,  exp: 8'd15,  name: "t1_3x5"};
      tbl[1] = '{a: 4'd15, b: 4'd15, exp: 8'hE1,  name: "t2_15x15"};
      tbl[2] = '{a: 4'd0,  b: 4'd9,  exp: 8'd0,   name: "t2_0x9"};
      tbl[3] = '{a: 4'd7,  b: 4'd4,  exp: 8'd28,  name: "t2_7x4"};
      tbl[4] = '{a: 4'd9,  b: 4'd0,  exp: 8'd0,   name: "zero_mplier"};
      tbl[5] = '{a: 4'd1,  b: 4'd13, exp: 8'd13,  name: "one_x13"};
      tbl[6] = '{a: 4'd12, b: 4'd11, exp: 8'd132, name: "12x11"};

      rst_n = 1'b0;
      start4 = 1'b0; a4 = 4'd0; b4 = 4'd0;
      start8 = 1'b0; a8 = 8'd0; b8 = 8'd0;
      #1;
      check("reset_busy", 32'(busy4), 32'd0);
      check("reset_done", 32'(done4), 32'd0);
      check("reset_p",    32'(p4),    32'd0);
      check("reset_p8",   32'(p8),    32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // T1/T2 and extra patterns from the vector table.
      for (int i = 0; i < 7; i++) begin
         op4(tbl[i].a, tbl[i].b, tbl[i].exp, tbl[i].name, 1'b0);
      end

      // T3: start held high; accepted at k, k+6, k+12.
      d0 = dones4;
      done_mask = 32'd0;
      @(negedge clk);
      a4 = 4'd2; b4 = 4'd3; start4 = 1'b1;
      q4.push_back(8'd6); q4.push_back(8'd99); q4.push_back(8'd15);
      @(posedge clk);
      for (int i = 0; i < 22; i++) begin
         @(negedge clk);
         if (i == 0)  begin a4 = 4'd9;  b4 = 4'd11; end
         if (i == 6)  begin a4 = 4'd15; b4 = 4'd1;  end
         if (i == 12) start4 = 1'b0;
         if (done4) done_mask[i] = 1'b1;
      end
      check("t3_done_timing", done_mask, 32'h0001_0410);
      check("t3_done_count", 32'(dones4 - d0), 32'd3);
      check("t3_queue_empty", 32'(q4.size()), 32'd0);

      // T4: asynchronous reset two cycles into RUN.
      @(negedge clk);
      a4 = 4'd13; b4 = 4'd11; start4 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start4 = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      check("t4_busy_before_reset", 32'(busy4), 32'd1);
      check("t4_p_before_reset", 32'(p4), 32'd15);
      #1;
      rst_n = 1'b0;
      #1;
      check("t4_busy_async", 32'(busy4), 32'd0);
      check("t4_done_async", 32'(done4), 32'd0);
      check("t4_p_async",    32'(p4),    32'd0);
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) @(negedge clk);
      check("t4_no_done_after_abort", 32'(q4.size()), 32'd0);
      op4(4'd6, 4'd6, 8'd36, "t4_after_reset", 1'b0);

      // T5: operands scrambled while busy.
      op4(4'd10, 4'd12, 8'd120, "t5_scramble", 1'b1);

      // T6: WIDTH=8 corner plus random pairs against a*b.
      op8(8'd255, 8'd255, "t6_255x255");
      check("t6_p_max", 32'(p8), 32'd65025);
      for (int i = 0; i < 1000; i++) begin
         op8(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), "t6_rand");
      end

      check("q4_drained", 32'(q4.size()), 32'd0);
      check("q8_drained", 32'(q8.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
